// File: rtl/alu_stage_two.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alu_stage_two : completes the upper half of a split 32-bit ADD and holds
//                 one ALU result in a valid/ready register with stall/flush.
// Revision      : 1.0
// ---------------------------------------------------------------------------
module alu_stage_two (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        addition_flag,
  input  logic        carry_bit,
  input  logic [15:0] last_16_bits_result,
  input  logic [31:0] stage1_aluout,
  input  logic        branch_enable_in,
  input  logic [15:0] a_hi,
  input  logic [15:0] b_hi,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] ALUOut,
  output logic        Branch_Enable,
  output logic        carry_out,
  output logic        overflow
);

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] alu_out_q, alu_out_d;
  logic        branch_q, branch_d;
  logic        carry_q, carry_d;
  logic        ovf_q, ovf_d;

  logic        accept;
  logic [16:0] hi_sum;

  // Flush blocks acceptance so a redirected instruction can never slip in.
  assign in_ready = !flush && ((state_q == ST_EMPTY) || out_ready);
  assign accept   = in_valid && in_ready;

  assign hi_sum = {1'b0, a_hi} + {1'b0, b_hi} + {16'h0000, carry_bit};

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else if (accept) begin
      state_d = ST_FULL;
    end else if ((state_q == ST_FULL) && out_ready) begin
      state_d = ST_EMPTY;
    end
  end

  // Data registers change only on accept; drain and flush leave them as-is.
  always_comb begin
    alu_out_d = alu_out_q;
    branch_d  = branch_q;
    carry_d   = carry_q;
    ovf_d     = ovf_q;
    if (accept) begin
      branch_d = branch_enable_in;
      if (addition_flag) begin
        alu_out_d = {hi_sum[15:0], last_16_bits_result};
        carry_d   = hi_sum[16];
        ovf_d     = (a_hi[15] == b_hi[15]) && (hi_sum[15] != a_hi[15]);
      end else begin
        alu_out_d = stage1_aluout;
        carry_d   = 1'b0;
        ovf_d     = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_EMPTY;
      alu_out_q <= 32'h0000_0000;
      branch_q  <= 1'b0;
      carry_q   <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      alu_out_q <= alu_out_d;
      branch_q  <= branch_d;
      carry_q   <= carry_d;
      ovf_q     <= ovf_d;
    end
  end

  assign out_valid     = (state_q == ST_FULL);
  assign ALUOut        = alu_out_q;
  assign Branch_Enable = branch_q;
  assign carry_out     = carry_q;
  assign overflow      = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_stage_two.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_alu_stage_two : directed plus randomized checks of alu_stage_two.
// Revision         : 1.0
// ---------------------------------------------------------------------------
module tb_alu_stage_two;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready;
  logic        addition_flag, carry_bit, branch_enable_in;
  logic [15:0] last_16_bits_result, a_hi, b_hi;
  logic [31:0] stage1_aluout;
  logic        out_valid, out_ready;
  logic [31:0] ALUOut;
  logic        Branch_Enable, carry_out, overflow;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model of the held entry.
  logic        m_valid = 1'b0;
  logic [31:0] m_alu   = 32'h0;
  logic        m_br    = 1'b0;
  logic        m_c     = 1'b0;
  logic        m_ov    = 1'b0;

  always #5 clk = ~clk;

  alu_stage_two dut (
    .clk                 (clk),
    .rst                 (rst),
    .flush               (flush),
    .in_valid            (in_valid),
    .in_ready            (in_ready),
    .addition_flag       (addition_flag),
    .carry_bit           (carry_bit),
    .last_16_bits_result (last_16_bits_result),
    .stage1_aluout       (stage1_aluout),
    .branch_enable_in    (branch_enable_in),
    .a_hi                (a_hi),
    .b_hi                (b_hi),
    .out_valid           (out_valid),
    .out_ready           (out_ready),
    .ALUOut              (ALUOut),
    .Branch_Enable       (Branch_Enable),
    .carry_out           (carry_out),
    .overflow            (overflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: check in_ready, advance the model, then check registered outputs.
  task automatic tick();
    logic        exp_ready, acc;
    logic [32:0] s33;
    int          hs;
    #1;
    exp_ready = !flush && (!m_valid || out_ready);
    if (!rst) chk("in_ready", {31'b0, in_ready}, {31'b0, exp_ready});
    acc = in_valid && exp_ready;
    if (rst) begin
      m_valid = 1'b0; m_alu = 32'h0; m_br = 1'b0; m_c = 1'b0; m_ov = 1'b0;
    end else if (flush) begin
      m_valid = 1'b0;
    end else if (acc) begin
      m_valid = 1'b1;
      m_br    = branch_enable_in;
      if (addition_flag) begin
        s33   = {1'b0, a_hi, 16'h0} + {1'b0, b_hi, 16'h0} + (33'(carry_bit) << 16);
        m_alu = s33[31:0] | {16'h0, last_16_bits_result};
        m_c   = s33[32];
        hs    = int'($signed(a_hi)) + int'($signed(b_hi)) + int'(carry_bit);
        m_ov  = (hs > 32767) || (hs < -32768);
      end else begin
        m_alu = stage1_aluout;
        m_c   = 1'b0;
        m_ov  = 1'b0;
      end
    end else if (m_valid && out_ready) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    chk("out_valid",     {31'b0, out_valid},     {31'b0, m_valid});
    chk("ALUOut",        ALUOut,                 m_alu);
    chk("Branch_Enable", {31'b0, Branch_Enable}, {31'b0, m_br});
    chk("carry_out",     {31'b0, carry_out},     {31'b0, m_c});
    chk("overflow",      {31'b0, overflow},      {31'b0, m_ov});
  endtask

  task automatic set_add(input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] lo, input logic cb);
    in_valid = 1'b1; addition_flag = 1'b1;
    a_hi = a; b_hi = b; last_16_bits_result = lo; carry_bit = cb;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    addition_flag = 1'b0; carry_bit = 1'b0; branch_enable_in = 1'b0;
    last_16_bits_result = 16'h0; stage1_aluout = 32'h0; a_hi = 16'h0; b_hi = 16'h0;

    @(posedge clk);
    #1;
    tick();
    tick();
    rst = 1'b0;
    chk("reset_ALUOut", ALUOut, 32'h0);
    #1;
    chk("reset_in_ready", {31'b0, in_ready}, 32'h1);

    // ADD with low-half carry
    set_add(16'h0000, 16'h0000, 16'h0000, 1'b1);
    tick();
    chk("add_carry_result", ALUOut, 32'h0001_0000);
    chk("add_carry_cout",   {31'b0, carry_out}, 32'h0);

    // Signed overflow
    set_add(16'h7FFF, 16'h0001, 16'h0000, 1'b0);
    tick();
    chk("ovf_result", ALUOut, 32'h8000_0000);
    chk("ovf_flag",   {31'b0, overflow}, 32'h1);

    // Full wrap-around
    set_add(16'hFFFF, 16'h0000, 16'h0000, 1'b1);
    tick();
    chk("wrap_result", ALUOut, 32'h0);
    chk("wrap_cout",   {31'b0, carry_out}, 32'h1);

    // Pass-through then a 3-cycle stall
    addition_flag = 1'b0; stage1_aluout = 32'h1234_5678; branch_enable_in = 1'b1;
    a_hi = 16'hFFFF; b_hi = 16'hFFFF; carry_bit = 1'b1;
    tick();
    chk("pass_result", ALUOut, 32'h1234_5678);
    stage1_aluout = 32'hDEAD_BEEF; branch_enable_in = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_hold", ALUOut, 32'h1234_5678);
      chk("stall_br",   {31'b0, Branch_Enable}, 32'h1);
    end
    out_ready = 1'b1;
    tick();
    chk("stall_release", ALUOut, 32'hDEAD_BEEF);

    // Back-to-back accepts
    for (int i = 0; i < 4; i++) begin
      stage1_aluout = 32'hA000_0000 + 32'(i);
      tick();
      chk("b2b_valid", {31'b0, out_valid}, 32'h1);
      chk("b2b_data",  ALUOut, 32'hA000_0000 + 32'(i));
    end

    // Flush while FULL with a pending input
    flush = 1'b1; stage1_aluout = 32'hCAFE_F00D;
    tick();
    chk("flush_valid", {31'b0, out_valid}, 32'h0);
    chk("flush_nocap", ALUOut, 32'hA000_0003);
    flush = 1'b0;

    // Reset while FULL and stalled
    stage1_aluout = 32'h5555_AAAA; branch_enable_in = 1'b1;
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    chk("rst_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_data",  ALUOut, 32'h0);
    rst = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      rst                 = ($urandom_range(0, 59) == 0);
      flush               = ($urandom_range(0, 15) == 0);
      in_valid            = ($urandom_range(0, 3) != 0);
      out_ready           = ($urandom_range(0, 2) != 0);
      addition_flag       = $urandom_range(0, 1) == 1;
      carry_bit           = $urandom_range(0, 1) == 1;
      branch_enable_in    = $urandom_range(0, 1) == 1;
      last_16_bits_result = 16'($urandom);
      stage1_aluout       = $urandom;
      a_hi                = 16'($urandom);
      b_hi                = 16'($urandom);
      if ($urandom_range(0, 7) == 0) a_hi = 16'hFFFF;
      if ($urandom_range(0, 7) == 0) b_hi = 16'h7FFF;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
